// File: rtl/pc8001m_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc8001m_pkg
// Description : Shared constants for the PC-8001 ROM loader: FSM state
//               encoding and default download index / reset pulse length.
// Revision    : 1.0 - initial release
// ============================================================================
package pc8001m_pkg;

  // OSD "F,BIND88" entry index and post-download core reset length
  localparam logic [7:0] ROM_INDEX_DEFAULT  = 8'd1;
  localparam int         RST_CYCLES_DEFAULT = 16;

  // Arbiter state encoding
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CPU_RD  = 3'd1;
  localparam logic [2:0] ST_CPU_DAT = 3'd2;
  localparam logic [2:0] ST_DL      = 3'd3;
  localparam logic [2:0] ST_DL_WR   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // The CPU is stalled whenever the loader owns the memory or the core is
  // being held in reset after a load.
  function automatic logic is_hold(state_t s);
    return (s == ST_DL) || (s == ST_DL_WR) || (s == ST_DONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_load_arb_pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretch
// Description : Emits a pulse exactly LEN cycles long starting the cycle
//               after trig; 'last' flags the final high cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretch #(
  parameter int LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic pulse,
  output logic last
);

  localparam int CW = $clog2(LEN + 1);

  logic [CW-1:0] cnt;

  // Down-counter: loaded on trigger, runs to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (trig) begin
      cnt <= CW'(LEN);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign pulse = (cnt != '0);
  assign last  = (cnt == CW'(1));

endmodule
`default_nettype wire

// File: rtl/rom_load_arb.sv
`default_nettype none
// ============================================================================
// Module      : rom_load_arb
// Description : Arbitrates a shared single-port ROM RAM between CPU reads and
//               hps_io ROM downloads; download has priority, a write arriving
//               mid-read is parked in a one-byte buffer under ioctl_wait.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_load_arb
  import pc8001m_pkg::*;
#(
  parameter int         ADDR_W     = 15,
  parameter logic [7:0] ROM_INDEX  = ROM_INDEX_DEFAULT,
  parameter int         RST_CYCLES = RST_CYCLES_DEFAULT
) (
  input  logic              clk_sys,
  input  logic              reset,
  // hps_io download port
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  // CPU read port
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  // shared RAM (1-cycle read latency)
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic [7:0]        mem_dout,
  // status
  output logic              cpu_hold,
  output logic              core_reset,
  output logic              rom_loaded,
  output logic              dl_overflow,
  output logic [ADDR_W:0]   bytes_loaded
);

  localparam logic [24:0]   MEM_SIZE = 25'(1) << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  state_t            state_nx;
  logic              armed;       // download line seen low since last reset
  logic              dl_pend;     // download start seen while a read was in flight
  logic              buf_valid;
  logic [24:0]       buf_addr;
  logic [7:0]        buf_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        dout_q;
  logic              wait_q;
  logic              ps_last;

  logic dl_start;
  logic in_read;
  logic take_wr;
  logic dl_end;
  logic wr_in_range;
  logic buf_in_range;
  logic drop_write;

  assign dl_start     = ioctl_download && (ioctl_index == ROM_INDEX) && armed;
  assign in_read      = (state == ST_CPU_RD) || (state == ST_CPU_DAT);
  assign take_wr      = in_read && ioctl_wr && dl_start && !buf_valid;
  assign dl_end       = (state == ST_DL) && !ioctl_download;
  assign wr_in_range  = (ioctl_addr < MEM_SIZE);
  assign buf_in_range = (buf_addr < MEM_SIZE);

  assign mem_we     = ((state == ST_DL) && ioctl_download && ioctl_wr && wr_in_range) ||
                      ((state == ST_DL_WR) && buf_in_range);
  assign drop_write = ((state == ST_DL) && ioctl_download && ioctl_wr && !wr_in_range) ||
                      ((state == ST_DL_WR) && !buf_in_range);

  // Next-state logic; a parked byte is flushed before entering DL proper
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (dl_start)     state_nx = ST_DL;
        else if (cpu_req) state_nx = ST_CPU_RD;
      end
      ST_CPU_RD:  state_nx = ST_CPU_DAT;
      ST_CPU_DAT: begin
        if (buf_valid || take_wr)     state_nx = ST_DL_WR;
        else if (dl_pend || dl_start) state_nx = ST_DL;
        else                          state_nx = ST_IDLE;
      end
      ST_DL:    if (!ioctl_download) state_nx = ST_DONE;
      ST_DL_WR: state_nx = ST_DL;
      ST_DONE:  if (ps_last) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // State, read datapath, write buffer and download status registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= ST_IDLE;
      armed        <= 1'b0;
      dl_pend      <= 1'b0;
      buf_valid    <= 1'b0;
      buf_addr     <= '0;
      buf_data     <= '0;
      rd_addr      <= '0;
      dout_q       <= '0;
      wait_q       <= 1'b0;
      rom_loaded   <= 1'b0;
      dl_overflow  <= 1'b0;
      bytes_loaded <= '0;
    end else begin
      state <= state_nx;

      if (!ioctl_download) armed <= 1'b1;

      dl_pend <= (state == ST_CPU_RD) && dl_start;

      if (state == ST_IDLE)    rd_addr <= cpu_addr;
      if (state == ST_CPU_DAT) dout_q  <= mem_dout;

      if (take_wr) begin
        buf_valid <= 1'b1;
        buf_addr  <= ioctl_addr;
        buf_data  <= ioctl_dout;
        wait_q    <= 1'b1;
      end else if (state == ST_DL_WR) begin
        buf_valid <= 1'b0;
        wait_q    <= 1'b0;
      end

      // Writes only happen in DL/DL_WR, so the clear never races a count
      if (dl_start && ((state == ST_IDLE) || in_read)) begin
        bytes_loaded <= '0;
        dl_overflow  <= 1'b0;
      end else begin
        if (mem_we && (bytes_loaded != CNT_MAX)) bytes_loaded <= bytes_loaded + (ADDR_W+1)'(1);
        if (drop_write)                          dl_overflow  <= 1'b1;
      end

      if (dl_end) rom_loaded <= 1'b1;
    end
  end

  // RAM address/data steering per state
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    if (state == ST_CPU_RD) begin
      mem_addr = rd_addr;
    end else if (mem_we && (state == ST_DL)) begin
      mem_addr = ioctl_addr[ADDR_W-1:0];
      mem_din  = ioctl_dout;
    end else if (mem_we && (state == ST_DL_WR)) begin
      mem_addr = buf_addr[ADDR_W-1:0];
      mem_din  = buf_data;
    end
  end

  assign cpu_ack    = (state == ST_CPU_DAT);
  assign cpu_dout   = (state == ST_CPU_DAT) ? mem_dout : dout_q;
  assign cpu_hold   = is_hold(state);
  assign ioctl_wait = wait_q;

  pulse_stretch #(
    .LEN (RST_CYCLES)
  ) u_rst_pulse (
    .clk   (clk_sys),
    .rst   (reset),
    .trig  (dl_end),
    .pulse (core_reset),
    .last  (ps_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_rom_load_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_load_arb
// Description : Self-checking bench for rom_load_arb with a behavioural RAM
//               and memory/status reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_load_arb;

  localparam int ADDR_W = 15;
  localparam int MEM_N  = 1 << ADDR_W;
  localparam int RSTC   = 16;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_dout;
  logic              cpu_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_we;
  logic [7:0]        mem_dout;
  logic              cpu_hold;
  logic              core_reset;
  logic              rom_loaded;
  logic              dl_overflow;
  logic [ADDR_W:0]   bytes_loaded;

  always #5 clk_sys = ~clk_sys;

  rom_load_arb #(
    .ADDR_W     (ADDR_W),
    .ROM_INDEX  (8'd1),
    .RST_CYCLES (RSTC)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .cpu_dout       (cpu_dout),
    .cpu_ack        (cpu_ack),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_we         (mem_we),
    .mem_dout       (mem_dout),
    .cpu_hold       (cpu_hold),
    .core_reset     (core_reset),
    .rom_loaded     (rom_loaded),
    .dl_overflow    (dl_overflow),
    .bytes_loaded   (bytes_loaded)
  );

  // Synchronous RAM with a backdoor preload port and write accounting
  logic [7:0]        ram [0:MEM_N-1];
  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [7:0]        bd_data;
  int                n_we = 0;
  int                n_bad_we = 0;

  always @(posedge clk_sys) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_din;
      n_we <= n_we + 1;
      if (!cpu_hold) n_bad_we <= n_bad_we + 1;
    end else if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end
    mem_dout <= ram[mem_addr];
  end

  // Reference model state
  logic [7:0] mdl [0:MEM_N-1];
  int         known_q[$];
  int         dl_a[$];
  logic [7:0] dl_d[$];
  int         exp_bytes;
  bit         exp_ovf;
  bit         exp_rom;
  logic [7:0] last_dout;
  int         we_mark;
  int         exp_wrs;
  int         n_pass = 0;
  int         n_chk  = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic preload(int a, logic [7:0] d);
    bd_we = 1'b1; bd_addr = ADDR_W'(a); bd_data = d;
    tick();
    bd_we = 1'b0;
    mdl[a] = d;
    known_q.push_back(a);
  endtask

  task automatic check_zero(string tag);
    settle();
    chk({tag, " cpu_dout"}, cpu_dout, 0);
    chk({tag, " cpu_ack"}, cpu_ack, 0);
    chk({tag, " ioctl_wait"}, ioctl_wait, 0);
    chk({tag, " core_reset"}, core_reset, 0);
    chk({tag, " rom_loaded"}, rom_loaded, 0);
    chk({tag, " dl_overflow"}, dl_overflow, 0);
    chk({tag, " bytes_loaded"}, bytes_loaded, 0);
    chk({tag, " cpu_hold"}, cpu_hold, 0);
    chk({tag, " mem_we"}, mem_we, 0);
  endtask

  // One CPU read: request cycle N, ack and data in N+2
  task automatic do_read(int a, string tag);
    logic [7:0] e;
    e = mdl[a];
    cpu_req = 1'b1; cpu_addr = ADDR_W'(a);
    settle();
    chk({tag, " ack@N"}, cpu_ack, 0);
    chk({tag, " dout held"}, cpu_dout, last_dout);
    chk({tag, " hold@N"}, cpu_hold, 0);
    tick();
    cpu_req = 1'b0;
    settle();
    chk({tag, " ack@N+1"}, cpu_ack, 0);
    tick();
    settle();
    chk({tag, " ack@N+2"}, cpu_ack, 1);
    chk({tag, " data@N+2"}, cpu_dout, e);
    tick();
    last_dout = e;
  endtask

  task automatic read_random(int n, string tag);
    for (int i = 0; i < n; i++) begin
      do_read(known_q[$urandom_range(0, known_q.size() - 1)], tag);
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  // Issue the queued download writes; 'ours' says whether the loader is active
  task automatic dl_write_seq(bit ours, string tag);
    bit inr;
    int gaps;
    for (int i = 0; i < dl_a.size(); i++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        settle();
        chk({tag, " gap we"}, mem_we, 0);
        chk({tag, " hold"}, cpu_hold, 32'(ours));
        tick();
      end
      inr = (dl_a[i] < MEM_N);
      ioctl_wr = 1'b1; ioctl_addr = 25'(dl_a[i]); ioctl_dout = dl_d[i];
      settle();
      chk({tag, " bytes"}, bytes_loaded, exp_bytes);
      chk({tag, " ovf"}, dl_overflow, 32'(exp_ovf));
      chk({tag, " we"}, mem_we, 32'(ours && inr));
      if (ours && inr) begin
        chk({tag, " addr"}, mem_addr, dl_a[i]);
        chk({tag, " din"}, mem_din, dl_d[i]);
        mdl[dl_a[i]] = dl_d[i];
        known_q.push_back(dl_a[i]);
        exp_wrs++;
        if (exp_bytes < MEM_N) exp_bytes++;
      end else if (ours) begin
        exp_ovf = 1'b1;
      end
      tick();
      ioctl_wr = 1'b0;
    end
  endtask

  // Drop ioctl_download and check the post-load reset pulse and status
  task automatic dl_end(bit ours, string tag);
    int hi;
    hi = 0;
    ioctl_download = 1'b0;
    settle();
    chk({tag, " core_reset@drop"}, core_reset, 0);
    tick();
    if (ours) exp_rom = 1'b1;
    for (int c = 0; c < RSTC + 4; c++) begin
      settle();
      if (core_reset === 1'b1) hi++;
      if (c == 0) begin
        chk({tag, " rom_loaded"}, rom_loaded, 32'(exp_rom));
        chk({tag, " hold@done"}, cpu_hold, 32'(ours));
      end
      tick();
    end
    settle();
    chk({tag, " reset pulse len"}, hi, ours ? RSTC : 0);
    chk({tag, " hold after"}, cpu_hold, 0);
    chk({tag, " bytes final"}, bytes_loaded, exp_bytes);
    chk({tag, " ovf final"}, dl_overflow, 32'(exp_ovf));
    chk({tag, " write count"}, n_we - we_mark, exp_wrs);
    tick();
  endtask

  task automatic do_download(logic [7:0] idx, string tag);
    bit ours;
    ours = (idx == 8'd1);
    we_mark = n_we; exp_wrs = 0;
    ioctl_download = 1'b1; ioctl_index = idx;
    settle();
    chk({tag, " hold@start"}, cpu_hold, 0);
    tick();
    if (ours) begin exp_bytes = 0; exp_ovf = 1'b0; end
    dl_write_seq(ours, tag);
    dl_end(ours, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a;
    int e;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; cpu_req = 1'b0; cpu_addr = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    exp_bytes = 0; exp_ovf = 1'b0; exp_rom = 1'b0; last_dout = 8'h00;
    we_mark = 0; exp_wrs = 0;

    // Reset state
    tick(); tick();
    check_zero("reset");
    tick();
    reset = 1'b0;
    tick(); tick();

    // Basic read of a preloaded byte, then random reads
    preload(16'h0123, 8'hA5);
    for (int i = 0; i < 8; i++) preload($urandom_range(0, MEM_N - 1), 8'($urandom));
    do_read(16'h0123, "read0123");
    read_random(10, "rdrand");

    // Four-byte ROM load at 0..3
    dl_a = '{0, 1, 2, 3};
    dl_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_download(8'd1, "load4");
    for (int i = 0; i < 4; i++) do_read(i, "load4 rd");

    // Download write arriving during a CPU read
    a = known_q[$urandom_range(0, known_q.size() - 1)];
    e = 16'h0200 + int'($urandom_range(0, 255));
    we_mark = n_we; exp_wrs = 1;
    cpu_req = 1'b1; cpu_addr = ADDR_W'(a);
    settle(); chk("wrmid ack@N", cpu_ack, 0); tick();
    cpu_req = 1'b0; ioctl_download = 1'b1; ioctl_index = 8'd1;
    ioctl_wr = 1'b1; ioctl_addr = 25'(e); ioctl_dout = 8'h5C;
    settle(); chk("wrmid wait@N+1", ioctl_wait, 0); chk("wrmid we@N+1", mem_we, 0); tick();
    ioctl_wr = 1'b0;
    settle();
    chk("wrmid ack@N+2", cpu_ack, 1); chk("wrmid data@N+2", cpu_dout, mdl[a]);
    chk("wrmid wait@N+2", ioctl_wait, 1); chk("wrmid we@N+2", mem_we, 0);
    tick();
    last_dout = mdl[a];
    settle();
    chk("wrmid wait@N+3", ioctl_wait, 1); chk("wrmid we@N+3", mem_we, 1);
    chk("wrmid addr@N+3", mem_addr, e); chk("wrmid din@N+3", mem_din, 8'h5C);
    tick();
    settle(); chk("wrmid wait@N+4", ioctl_wait, 0); chk("wrmid hold@N+4", cpu_hold, 1); tick();
    mdl[e] = 8'h5C; known_q.push_back(e);
    exp_bytes = 1; exp_ovf = 1'b0;
    dl_end(1'b1, "wrmid");
    do_read(e, "wrmid rd");

    // Out-of-range write is dropped and flagged
    dl_a = '{5, 32'h8000, 6};
    dl_d = '{8'h5A, 8'h77, 8'h66};
    do_download(8'd1, "ovf");
    do_read(5, "ovf rd");

    // Foreign index: ignored entirely, CPU keeps reading
    ioctl_download = 1'b1; ioctl_index = 8'd2;
    tick();
    read_random(3, "idx2 rd");
    we_mark = n_we; exp_wrs = 0;
    dl_a = '{7, 8, 9};
    dl_d = '{8'hE1, 8'hE2, 8'hE3};
    dl_write_seq(1'b0, "idx2");
    read_random(2, "idx2 rd2");
    dl_end(1'b0, "idx2");

    // Random downloads with random indices and occasional overflow
    for (int k = 0; k < 4; k++) begin
      dl_a.delete(); dl_d.delete();
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 5) == 0) dl_a.push_back(MEM_N + int'($urandom_range(0, 1023)));
        else                           dl_a.push_back(int'($urandom_range(0, MEM_N - 1)));
        dl_d.push_back(8'($urandom));
      end
      do_download(($urandom_range(0, 2) == 0) ? 8'd3 : 8'd1, "dlrand");
      read_random(4, "dlrand rd");
    end

    // Reset after two of four writes
    we_mark = n_we; exp_wrs = 0;
    ioctl_download = 1'b1; ioctl_index = 8'd1;
    tick();
    exp_bytes = 0; exp_ovf = 1'b0;
    dl_a = '{16'h0300, 16'h0301};
    dl_d = '{8'hC1, 8'hC2};
    dl_write_seq(1'b1, "rstmid");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_rom = 1'b0; exp_bytes = 0; exp_ovf = 1'b0; last_dout = 8'h00;
    check_zero("rstmid");
    tick();
    dl_a = '{16'h0302, 16'h0303};
    dl_d = '{8'hC3, 8'hC4};
    dl_write_seq(1'b0, "rstmid after");
    dl_end(1'b0, "rstmid drop");
    dl_a = '{16'h0302, 16'h0303};
    do_download(8'd1, "reload");
    for (int i = 0; i < 4; i++) do_read(16'h0300 + i, "reload rd");

    chk("no write outside download", n_bad_we, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_load_arb.md
ROM_LOAD_ARB -- requirements
Module: rom_load_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning shared ROM memory is 2^ADDR_W bytes (32 KB).
REQ-002 SHALL have parameter ROM_INDEX, default 8'd1, meaning the ioctl_index of the OSD "F,BIND88" file entry.
REQ-003 SHALL have parameter RST_CYCLES, default 16, meaning the length of the core_reset pulse after a download.
REQ-004 SHALL have port clk_sys, input, width 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-006 SHALL have ports ioctl_download (in, 1), ioctl_index (in, 8), ioctl_wr (in, 1, one-cycle strobe), ioctl_addr (in, 25), ioctl_dout (in, 8) from hps_io.
REQ-007 SHALL have port ioctl_wait, output, width 1: holds off the next ioctl_wr.
REQ-008 SHALL have ports cpu_req (in, 1), cpu_addr (in, ADDR_W), cpu_dout (out, 8) and cpu_ack (out, 1, one-cycle pulse) for CPU reads.
REQ-009 SHALL have ports mem_addr (out, ADDR_W), mem_din (out, 8), mem_we (out, 1) and mem_dout (in, 8) to a synchronous single-port RAM with 1-cycle read latency.
REQ-010 SHALL have ports cpu_hold (out, 1), core_reset (out, 1), rom_loaded (out, 1), dl_overflow (out, 1) and bytes_loaded (out, ADDR_W+1).

Function
REQ-011 SHALL implement FSM states IDLE, CPU_RD, CPU_DAT, DL, DL_WR and DONE.
REQ-012 SHALL start a download when ioctl_download=1 and ioctl_index==ROM_INDEX; other indices are ignored entirely.
REQ-013 SHALL give download priority: a download start seen in IDLE goes to DL, and seen during CPU_RD/CPU_DAT it goes to DL after that read completes.
REQ-014 SHALL handle a CPU read as follows: cpu_req sampled in IDLE with no download start -> CPU_RD (mem_addr=cpu_addr) -> CPU_DAT (cpu_dout<=mem_dout, cpu_ack=1) -> IDLE, so ack arrives 2 cycles after the req cycle.
REQ-015 SHALL hold cpu_dout stable between acks, and SHALL accept back-to-back requests (a new req is sampled in the IDLE cycle after the ack).
REQ-016 SHALL drive cpu_hold=1 in DL, DL_WR and DONE; cpu_req in those states is neither acked nor queued.
REQ-017 SHALL, in DL, on ioctl_wr with ioctl_addr < 2^ADDR_W, drive mem_we=1, mem_addr=ioctl_addr[ADDR_W-1:0] and mem_din=ioctl_dout for exactly that cycle.
REQ-018 SHALL, on ioctl_wr arriving while a CPU read is in flight, latch addr/data into a one-byte buffer, assert ioctl_wait, write the buffer in DL_WR, and deassert ioctl_wait on the following cycle.
REQ-019 SHALL drop writes with ioctl_addr >= 2^ADDR_W, setting dl_overflow (sticky until the next download start).
REQ-020 SHALL increment bytes_loaded on each performed write, saturating at 2^ADDR_W, and clear it at download start.
REQ-021 SHALL, on ioctl_download falling in DL, go to DONE, set rom_loaded=1 and assert core_reset for exactly RST_CYCLES cycles, then return to IDLE.
REQ-022 SHALL ignore a new download start during DONE until the pulse ends, then honour it if still asserted.
REQ-023 SHALL not write memory outside DL and DL_WR; mem_we=0 in all other states.

Reset
REQ-024 SHALL on reset set state=IDLE and all outputs to 0 (cpu_dout=8'h00, ioctl_wait=0, core_reset=0, rom_loaded=0, dl_overflow=0, bytes_loaded=0, cpu_hold=0, mem_we=0).
REQ-025 SHALL, on reset mid-download, abort immediately, discard the buffered byte, and wait for ioctl_download to go 0 and then 1 again before re-entering DL.

Structure
REQ-026 SHALL place the state enum and the ROM_INDEX/RST_CYCLES defaults in shared package pc8001m_pkg.
REQ-027 SHALL implement the core_reset pulse timer as sub-module pulse_stretch (parameter LEN), triggered on DONE entry.

Verification
REQ-028 SHALL cover: preload mem[0x0123]=8'hA5, pulse cpu_req with addr 0x0123 in cycle N -> cpu_ack=1 and cpu_dout=8'hA5 in cycle N+2.
REQ-029 SHALL cover: index 1, write 4 bytes 11,22,33,44 at 0..3, drop download -> mem holds those values, bytes_loaded=4, core_reset high for 16 cycles, rom_loaded=1.
REQ-030 SHALL cover: ioctl_wr in the cycle after cpu_req -> ack delivered, ioctl_wait=1 for 2 cycles, byte written once.
REQ-031 SHALL cover: write at ioctl_addr 0x8000 -> no mem_we, dl_overflow=1, bytes_loaded unchanged.
REQ-032 SHALL cover: index 2 download -> no mem_we, cpu_hold=0, CPU reads still acked.
REQ-033 SHALL cover: reset asserted after 2 of 4 writes -> all outputs 0, no further writes until ioctl_download toggles.
